int_issue_scheduler: RTL



---
 rtl/int_issue_scheduler_pkg.sv | 34 +++
 rtl/int_issue_scheduler_if.sv | 42 ++++
 rtl/int_issue_scheduler_sched_pick.sv | 32 +++
 rtl/int_issue_scheduler.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/int_issue_scheduler_pkg.sv
// int_sched_pkg: shared types and constants for the integer issue scheduler.
// The issue-word field offsets are also used by EX00 when it decodes data_i,
// so both sides agree on the layout.
package int_sched_pkg;

  localparam int ISSUE_W = 18;
  localparam int TAG_W   = 6;
  localparam int ROB_LSB = 0;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 12;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rob;
    logic [TAG_W-1:0] rs1;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs2;
    logic             rs2_rdy;
  } sched_entry_t;

  function automatic logic [ISSUE_W-1:0] pack_issue(
    input logic [TAG_W-1:0] rob,
    input logic [TAG_W-1:0] rs1,
    input logic [TAG_W-1:0] rs2
  );
    logic [ISSUE_W-1:0] word;
    word = '0;
    word[ROB_LSB +: TAG_W] = rob;
    word[RS1_LSB +: TAG_W] = rs1;
    word[RS2_LSB +: TAG_W] = rs2;
    return word;
  endfunction

endpackage

// File: rtl/int_issue_scheduler_if.sv
// int_issue_scheduler_if: dispatch, wakeup, flush and issue signals of the
// integer issue scheduler.
//   master : dispatch/wakeup/flush side (drives enq_*, wk*, flush_i)
//   slave  : the scheduler (drives enq_ready_o, data_o, valid_o, count_o)
interface int_issue_scheduler_if
  import int_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PRF_W = 6
);

  logic                     flush_i;
  logic                     enq_valid_i;
  logic                     enq_ready_o;
  logic [TAG_W-1:0]         enq_rob_i;
  logic [PRF_W-1:0]         enq_rs1_i;
  logic [PRF_W-1:0]         enq_rs2_i;
  logic                     enq_rs1_rdy_i;
  logic                     enq_rs2_rdy_i;
  logic [PRF_W-1:0]         wk0_dest_i;
  logic                     wk0_valid_i;
  logic [PRF_W-1:0]         wk1_dest_i;
  logic                     wk1_valid_i;
  logic [ISSUE_W-1:0]       data_o;
  logic                     valid_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output flush_i, enq_valid_i, enq_rob_i, enq_rs1_i, enq_rs2_i,
           enq_rs1_rdy_i, enq_rs2_rdy_i, wk0_dest_i, wk0_valid_i,
           wk1_dest_i, wk1_valid_i,
    input  enq_ready_o, data_o, valid_o, count_o
  );

  modport slave (
    input  flush_i, enq_valid_i, enq_rob_i, enq_rs1_i, enq_rs2_i,
           enq_rs1_rdy_i, enq_rs2_rdy_i, wk0_dest_i, wk0_valid_i,
           wk1_dest_i, wk1_valid_i,
    output enq_ready_o, data_o, valid_o, count_o
  );

endinterface

// File: rtl/int_issue_scheduler_sched_pick.sv
// sched_pick: lowest-index-first priority encoder.
//   req : request vector, bit 0 has highest priority
//   gnt : one-hot grant (zero when no request)
//   idx : binary index of the granted bit (zero when no request)
//   any : at least one request present
module sched_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_issue_scheduler.sv
// int_issue_scheduler: collapsing, age-ordered integer issue queue feeding
// EX00. Index 0 holds the oldest micro-op; each cycle the oldest entry whose
// sources are ready (including same-cycle wakeups) is presented on data_o.
//   cpu_clock_i  : clock
//   cpu_resetn_i : asynchronous active-low reset
//   bus          : slave side of int_issue_scheduler_if (enqueue handshake,
//                  two wakeup ports, flush, issue word/valid, occupancy)
module int_issue_scheduler
  import int_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PRF_W = 6
) (
  input logic                  cpu_clock_i,
  input logic                  cpu_resetn_i,
  int_issue_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  sched_entry_t       ent_q   [DEPTH];
  logic [DEPTH-1:0]   vld_q;
  logic [CNT_W-1:0]   count_q;

  sched_entry_t       ent_cur [DEPTH];
  sched_entry_t       ent_ext [DEPTH+1];
  sched_entry_t       ent_nxt [DEPTH];
  sched_entry_t       enq_ent;
  logic [DEPTH-1:0]   elig;
  logic [DEPTH-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               enq_ready;
  logic               enq_fire;
  logic               issue_fire;
  logic [CNT_W-1:0]   wr_idx;
  logic [CNT_W-1:0]   count_nxt;
  logic [ISSUE_W-1:0] issue_word;
  logic [PRF_W-1:0]   wk0_tag;
  logic [PRF_W-1:0]   wk1_tag;

  // Tag 0 is the hard-wired always-ready register; a valid wakeup on either
  // port counts in the cycle it is broadcast.
  function automatic logic src_ready(
    input logic             rdy,
    input logic [TAG_W-1:0] tag,
    input logic             w0_vld,
    input logic [TAG_W-1:0] w0_tag,
    input logic             w1_vld,
    input logic [TAG_W-1:0] w1_tag
  );
    return rdy | (tag == '0) | (w0_vld & (tag == w0_tag)) |
           (w1_vld & (tag == w1_tag));
  endfunction

  assign wk0_tag = bus.wk0_dest_i;
  assign wk1_tag = bus.wk1_dest_i;

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_cur[i]         = ent_q[i];
      ent_cur[i].valid   = vld_q[i];
      ent_cur[i].rs1_rdy = src_ready(ent_q[i].rs1_rdy, ent_q[i].rs1,
                                     bus.wk0_valid_i, wk0_tag,
                                     bus.wk1_valid_i, wk1_tag);
      ent_cur[i].rs2_rdy = src_ready(ent_q[i].rs2_rdy, ent_q[i].rs2,
                                     bus.wk0_valid_i, wk0_tag,
                                     bus.wk1_valid_i, wk1_tag);
      elig[i] = ent_cur[i].valid & ent_cur[i].rs1_rdy & ent_cur[i].rs2_rdy;
    end
  end

  sched_pick #(
    .N (DEPTH)
  ) u_pick (
    .req (elig),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    issue_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick_gnt[i]) begin
        issue_word = issue_word | pack_issue(ent_q[i].rob, ent_q[i].rs1, ent_q[i].rs2);
      end
    end
  end

  always_comb begin
    enq_ent         = '0;
    enq_ent.valid   = 1'b1;
    enq_ent.rob     = bus.enq_rob_i;
    enq_ent.rs1     = bus.enq_rs1_i;
    enq_ent.rs2     = bus.enq_rs2_i;
    enq_ent.rs1_rdy = src_ready(bus.enq_rs1_rdy_i, bus.enq_rs1_i,
                                bus.wk0_valid_i, wk0_tag,
                                bus.wk1_valid_i, wk1_tag);
    enq_ent.rs2_rdy = src_ready(bus.enq_rs2_rdy_i, bus.enq_rs2_i,
                                bus.wk0_valid_i, wk0_tag,
                                bus.wk1_valid_i, wk1_tag);
  end

  // Registered count only: a slot freed by this cycle's issue is not offered.
  assign enq_ready  = (count_q < CNT_W'(DEPTH));
  assign enq_fire   = bus.enq_valid_i & enq_ready;
  assign issue_fire = pick_any;
  assign wr_idx     = count_q - CNT_W'(issue_fire);

  // Collapse above the issued slot, then drop the new op at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_ext[i] = ent_cur[i];
    end
    ent_ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (i >= int'(pick_idx))) begin
        ent_nxt[i] = ent_ext[i+1];
      end else begin
        ent_nxt[i] = ent_ext[i];
      end
      if (enq_fire && (wr_idx == CNT_W'(i))) begin
        ent_nxt[i] = enq_ent;
      end
      if (bus.flush_i) begin
        ent_nxt[i].valid = 1'b0;
      end
    end
  end

  assign count_nxt = bus.flush_i ? '0
                   : count_q + CNT_W'(enq_fire) - CNT_W'(issue_fire);

  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= ent_nxt[i].valid;
      end
    end
  end

  // Payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge cpu_clock_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_nxt[i];
    end
  end

  assign bus.enq_ready_o = enq_ready;
  assign bus.valid_o     = pick_any & ~bus.flush_i;
  assign bus.data_o      = issue_word;
  assign bus.count_o     = count_q;

endmodule
